// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM stage: data-memory req/ready access, branch resolve, MEM/WB register
// Optional feature macro: MEM_TIMEOUT_EN (abort ACCESS after TIMEOUT_CYC cycles, raise sticky mem_err)
module mem_access_stage #(
   parameter int DATA_W      = 64,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [4:0]        EX_MEM_rd,
   input  logic [DATA_W-1:0] EX_MEM_readData2,
   input  logic [DATA_W-1:0] EX_MEM_ALU_result,
   input  logic              EX_MEM_zero,
   input  logic [DATA_W-1:0] EX_MEM_pcOut,
   input  logic              EX_MEM_Branch,
   input  logic              EX_MEM_MemRead,
   input  logic              EX_MEM_MemWrite,
   input  logic              EX_MEM_regWrite,
   input  logic              EX_MEM_MemtoReg,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic [DATA_W-1:0] dmem_rdata,
   input  logic              dmem_ready,
   output logic              mem_stall,
   output logic              pc_src,
   output logic [DATA_W-1:0] branch_target,
   output logic [4:0]        MEM_WB_rd,
   output logic [DATA_W-1:0] MEM_WB_ALU_result,
   output logic [DATA_W-1:0] MEM_WB_readData,
   output logic              MEM_WB_regWrite,
   output logic              MEM_WB_MemtoReg,
   output logic              mem_err
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              mem_op;
   logic              timeout_hit;

   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [4:0]        wb_rd_q, wb_rd_d;
   logic [DATA_W-1:0] wb_alu_q, wb_alu_d;
   logic [DATA_W-1:0] wb_rdata_q, wb_rdata_d;
   logic              wb_rw_q, wb_rw_d;
   logic              wb_m2r_q, wb_m2r_d;

   assign mem_op = EX_MEM_MemRead | EX_MEM_MemWrite;

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mem_err_q, mem_err_d;

   // ACCESS-cycle counter: zero outside ACCESS so each access starts counting from its first cycle
   always_comb begin
      cnt_d       = '0;
      timeout_hit = 1'b0;
      if (state_q == S_ACCESS) begin
         cnt_d       = cnt_q + 1'b1;
         timeout_hit = ~dmem_ready & (cnt_q == CNT_LAST);
      end
      mem_err_d = mem_err_q | timeout_hit;
   end

   // Timeout counter and sticky error flag registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q     <= '0;
         mem_err_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         mem_err_q <= mem_err_d;
      end
   end

   assign mem_err = mem_err_q;
`else
   assign timeout_hit = 1'b0;
   assign mem_err     = 1'b0;
`endif

   // FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: one IDLE cycle before every access, DONE always returns to IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (mem_op) state_d = S_ACCESS;
         S_ACCESS: if (dmem_ready || timeout_hit) state_d = S_DONE;
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // FSM outputs: request is a pure state decode, stall covers the IDLE-with-op and ACCESS cycles
   always_comb begin
      dmem_req   = (state_q == S_ACCESS);
      dmem_we    = (state_q == S_ACCESS) & EX_MEM_MemWrite;
      dmem_addr  = EX_MEM_ALU_result;
      dmem_wdata = EX_MEM_readData2;
      mem_stall  = (state_q == S_ACCESS) | ((state_q == S_IDLE) & mem_op);
   end

   // Branch resolution is suppressed while the stage is holding upstream
   assign pc_src        = EX_MEM_Branch & EX_MEM_zero & ~mem_stall;
   assign branch_target = EX_MEM_pcOut;

   // Read-data capture: a write (including read+write) or a timeout captures zero
   always_comb begin
      rdata_d = rdata_q;
      if (state_q == S_ACCESS) begin
         if (dmem_ready) begin
            rdata_d = EX_MEM_MemWrite ? '0 : dmem_rdata;
         end else if (timeout_hit) begin
            rdata_d = '0;
         end
      end
   end

   // MEM/WB next value: pass-through for non-memory ops, completion in DONE, bubble otherwise
   always_comb begin
      wb_rd_d    = wb_rd_q;
      wb_alu_d   = wb_alu_q;
      wb_rdata_d = wb_rdata_q;
      wb_rw_d    = wb_rw_q;
      wb_m2r_d   = wb_m2r_q;
      if ((state_q == S_IDLE) && !mem_op) begin
         wb_rd_d    = EX_MEM_rd;
         wb_alu_d   = EX_MEM_ALU_result;
         wb_rdata_d = '0;
         wb_rw_d    = EX_MEM_regWrite;
         wb_m2r_d   = EX_MEM_MemtoReg;
      end else if (state_q == S_DONE) begin
         wb_rd_d    = EX_MEM_rd;
         wb_alu_d   = EX_MEM_ALU_result;
         wb_rdata_d = rdata_q;
         wb_rw_d    = EX_MEM_regWrite;
         wb_m2r_d   = EX_MEM_MemtoReg;
      end else begin
         wb_rd_d  = 5'd0;
         wb_rw_d  = 1'b0;
         wb_m2r_d = 1'b0;
      end
   end

   // Read-data capture and MEM/WB pipeline registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rdata_q    <= '0;
         wb_rd_q    <= 5'd0;
         wb_alu_q   <= '0;
         wb_rdata_q <= '0;
         wb_rw_q    <= 1'b0;
         wb_m2r_q   <= 1'b0;
      end else begin
         rdata_q    <= rdata_d;
         wb_rd_q    <= wb_rd_d;
         wb_alu_q   <= wb_alu_d;
         wb_rdata_q <= wb_rdata_d;
         wb_rw_q    <= wb_rw_d;
         wb_m2r_q   <= wb_m2r_d;
      end
   end

   assign MEM_WB_rd         = wb_rd_q;
   assign MEM_WB_ALU_result = wb_alu_q;
   assign MEM_WB_readData   = wb_rdata_q;
   assign MEM_WB_regWrite   = wb_rw_q;
   assign MEM_WB_MemtoReg   = wb_m2r_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage
module tb_mem_access_stage;

   localparam int DATA_W = 64;
   localparam int TO_CYC = 4;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [4:0]        EX_MEM_rd;
   logic [DATA_W-1:0] EX_MEM_readData2, EX_MEM_ALU_result, EX_MEM_pcOut;
   logic              EX_MEM_zero, EX_MEM_Branch, EX_MEM_MemRead, EX_MEM_MemWrite;
   logic              EX_MEM_regWrite, EX_MEM_MemtoReg;
   logic              dmem_req, dmem_we;
   logic [DATA_W-1:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic              dmem_ready;
   logic              mem_stall, pc_src;
   logic [DATA_W-1:0] branch_target;
   logic [4:0]        MEM_WB_rd;
   logic [DATA_W-1:0] MEM_WB_ALU_result, MEM_WB_readData;
   logic              MEM_WB_regWrite, MEM_WB_MemtoReg, mem_err;

   int total = 0;
   int bad   = 0;

   mem_access_stage #(.DATA_W(DATA_W), .TIMEOUT_CYC(TO_CYC)) dut (
      .clk(clk), .reset_n(reset_n),
      .EX_MEM_rd(EX_MEM_rd), .EX_MEM_readData2(EX_MEM_readData2),
      .EX_MEM_ALU_result(EX_MEM_ALU_result), .EX_MEM_zero(EX_MEM_zero),
      .EX_MEM_pcOut(EX_MEM_pcOut), .EX_MEM_Branch(EX_MEM_Branch),
      .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_MemWrite(EX_MEM_MemWrite),
      .EX_MEM_regWrite(EX_MEM_regWrite), .EX_MEM_MemtoReg(EX_MEM_MemtoReg),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
      .mem_stall(mem_stall), .pc_src(pc_src), .branch_target(branch_target),
      .MEM_WB_rd(MEM_WB_rd), .MEM_WB_ALU_result(MEM_WB_ALU_result),
      .MEM_WB_readData(MEM_WB_readData), .MEM_WB_regWrite(MEM_WB_regWrite),
      .MEM_WB_MemtoReg(MEM_WB_MemtoReg), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   task automatic clear_ex();
      EX_MEM_rd = 5'd0; EX_MEM_readData2 = '0; EX_MEM_ALU_result = '0; EX_MEM_pcOut = '0;
      EX_MEM_zero = 1'b0; EX_MEM_Branch = 1'b0; EX_MEM_MemRead = 1'b0; EX_MEM_MemWrite = 1'b0;
      EX_MEM_regWrite = 1'b0; EX_MEM_MemtoReg = 1'b0; dmem_ready = 1'b0; dmem_rdata = '0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      clear_ex();
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++; if ({dmem_req, mem_stall, mem_err} !== 3'b000) begin bad++; $display("FAIL reset_ctl got=%b want=000", {dmem_req, mem_stall, mem_err}); end
      total++; if ({MEM_WB_regWrite, MEM_WB_MemtoReg, MEM_WB_rd} !== 7'd0) begin bad++; $display("FAIL reset_wb_ctl got=%h want=0", {MEM_WB_regWrite, MEM_WB_MemtoReg, MEM_WB_rd}); end
      total++; if ({MEM_WB_ALU_result, MEM_WB_readData} !== 128'd0) begin bad++; $display("FAIL reset_wb_data got=%h want=0", {MEM_WB_ALU_result, MEM_WB_readData}); end
      reset_n = 1'b1;
   endtask

   task automatic test_alu_op();
      @(negedge clk);
      clear_ex();
      EX_MEM_rd = 5'd5; EX_MEM_ALU_result = 64'h2A; EX_MEM_regWrite = 1'b1;
      #1;
      total++; if (mem_stall !== 1'b0) begin bad++; $display("FAIL alu_stall_pre got=%b want=0", mem_stall); end
      @(posedge clk); #1;
      total++; if ({MEM_WB_regWrite, MEM_WB_MemtoReg, MEM_WB_rd} !== {1'b1, 1'b0, 5'd5}) begin bad++; $display("FAIL alu_wb_ctl got=%h want=%h", {MEM_WB_regWrite, MEM_WB_MemtoReg, MEM_WB_rd}, {1'b1, 1'b0, 5'd5}); end
      total++; if (MEM_WB_ALU_result !== 64'h2A) begin bad++; $display("FAIL alu_wb_result got=%h want=2a", MEM_WB_ALU_result); end
      total++; if (MEM_WB_readData !== 64'h0) begin bad++; $display("FAIL alu_wb_rdata got=%h want=0", MEM_WB_readData); end
      total++; if (mem_stall !== 1'b0) begin bad++; $display("FAIL alu_stall_post got=%b want=0", mem_stall); end
   endtask

   // Load with ready already high; Branch/zero also set to see pc_src masked by the stall
   task automatic test_load();
      @(negedge clk);
      clear_ex();
      EX_MEM_rd = 5'd7; EX_MEM_ALU_result = 64'h100; EX_MEM_MemRead = 1'b1;
      EX_MEM_regWrite = 1'b1; EX_MEM_MemtoReg = 1'b1; EX_MEM_Branch = 1'b1; EX_MEM_zero = 1'b1;
      dmem_ready = 1'b1; dmem_rdata = 64'hDEADBEEF;
      #1;
      total++; if ({mem_stall, dmem_req, pc_src} !== 3'b100) begin bad++; $display("FAIL load_idle got=%b want=100", {mem_stall, dmem_req, pc_src}); end
      @(posedge clk); #1;
      total++; if ({mem_stall, dmem_req, dmem_we, pc_src} !== 4'b1100) begin bad++; $display("FAIL load_access got=%b want=1100", {mem_stall, dmem_req, dmem_we, pc_src}); end
      total++; if (dmem_addr !== 64'h100) begin bad++; $display("FAIL load_addr got=%h want=100", dmem_addr); end
      total++; if ({MEM_WB_regWrite, MEM_WB_MemtoReg, MEM_WB_rd} !== 7'd0) begin bad++; $display("FAIL load_bubble1 got=%h want=0", {MEM_WB_regWrite, MEM_WB_MemtoReg, MEM_WB_rd}); end
      total++; if (MEM_WB_ALU_result !== 64'h2A) begin bad++; $display("FAIL load_bubble_hold got=%h want=2a", MEM_WB_ALU_result); end
      @(posedge clk); #1;
      total++; if ({mem_stall, dmem_req, pc_src} !== 3'b001) begin bad++; $display("FAIL load_done got=%b want=001", {mem_stall, dmem_req, pc_src}); end
      total++; if ({MEM_WB_regWrite, MEM_WB_MemtoReg, MEM_WB_rd} !== 7'd0) begin bad++; $display("FAIL load_bubble2 got=%h want=0", {MEM_WB_regWrite, MEM_WB_MemtoReg, MEM_WB_rd}); end
      @(posedge clk); #1;
      total++; if ({MEM_WB_regWrite, MEM_WB_MemtoReg, MEM_WB_rd} !== {1'b1, 1'b1, 5'd7}) begin bad++; $display("FAIL load_wb_ctl got=%h want=%h", {MEM_WB_regWrite, MEM_WB_MemtoReg, MEM_WB_rd}, {1'b1, 1'b1, 5'd7}); end
      total++; if (MEM_WB_readData !== 64'hDEADBEEF) begin bad++; $display("FAIL load_wb_rdata got=%h want=deadbeef", MEM_WB_readData); end
      total++; if (MEM_WB_ALU_result !== 64'h100) begin bad++; $display("FAIL load_wb_result got=%h want=100", MEM_WB_ALU_result); end
      clear_ex();
   endtask

   task automatic test_branch();
      @(negedge clk);
      clear_ex();
      EX_MEM_Branch = 1'b1; EX_MEM_zero = 1'b1; EX_MEM_pcOut = 64'h40;
      #1;
      total++; if (pc_src !== 1'b1) begin bad++; $display("FAIL br_taken got=%b want=1", pc_src); end
      total++; if (branch_target !== 64'h40) begin bad++; $display("FAIL br_target got=%h want=40", branch_target); end
      EX_MEM_zero = 1'b0;
      #1;
      total++; if (pc_src !== 1'b0) begin bad++; $display("FAIL br_not_taken got=%b want=0", pc_src); end
      @(posedge clk); #1;
      total++; if (MEM_WB_readData !== 64'h0) begin bad++; $display("FAIL br_wb_rdata got=%h want=0", MEM_WB_readData); end
   endtask

   task automatic test_store();
      @(negedge clk);
      clear_ex();
      EX_MEM_rd = 5'd3; EX_MEM_ALU_result = 64'h80; EX_MEM_readData2 = 64'h55;
      EX_MEM_MemWrite = 1'b1; dmem_rdata = 64'h1234;
      #1;
      total++; if ({mem_stall, dmem_req} !== 2'b10) begin bad++; $display("FAIL st_idle got=%b want=10", {mem_stall, dmem_req}); end
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         total++; if ({mem_stall, dmem_req, dmem_we, MEM_WB_regWrite} !== 4'b1110) begin bad++; $display("FAIL st_access%0d got=%b want=1110", i, {mem_stall, dmem_req, dmem_we, MEM_WB_regWrite}); end
         total++; if ({dmem_addr, dmem_wdata} !== {64'h80, 64'h55}) begin bad++; $display("FAIL st_bus%0d got=%h want=%h", i, {dmem_addr, dmem_wdata}, {64'h80, 64'h55}); end
         total++; if (MEM_WB_readData !== 64'h0) begin bad++; $display("FAIL st_rdata%0d got=%h want=0", i, MEM_WB_readData); end
         if (i == 3) dmem_ready = 1'b1;
      end
      @(posedge clk); #1;
      total++; if ({mem_stall, dmem_req, MEM_WB_regWrite} !== 3'b000) begin bad++; $display("FAIL st_done got=%b want=000", {mem_stall, dmem_req, MEM_WB_regWrite}); end
      dmem_ready = 1'b0;
      @(posedge clk); #1;
      total++; if ({MEM_WB_regWrite, MEM_WB_MemtoReg, MEM_WB_rd} !== {1'b0, 1'b0, 5'd3}) begin bad++; $display("FAIL st_wb_ctl got=%h want=%h", {MEM_WB_regWrite, MEM_WB_MemtoReg, MEM_WB_rd}, {1'b0, 1'b0, 5'd3}); end
      total++; if ({MEM_WB_ALU_result, MEM_WB_readData} !== {64'h80, 64'h0}) begin bad++; $display("FAIL st_wb_data got=%h want=%h", {MEM_WB_ALU_result, MEM_WB_readData}, {64'h80, 64'h0}); end
      clear_ex();
   endtask

   // Two loads in a row: each one must pass through IDLE again (stall pattern 1,1,0 per op)
   task automatic test_back_to_back();
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         clear_ex();
         EX_MEM_rd = 5'(10 + k); EX_MEM_ALU_result = 64'h200 + 64'(8 * k);
         EX_MEM_MemRead = 1'b1; EX_MEM_regWrite = 1'b1; EX_MEM_MemtoReg = 1'b1;
         dmem_ready = 1'b1; dmem_rdata = 64'hA0 + 64'(k);
         #1;
         total++; if ({mem_stall, dmem_req} !== 2'b10) begin bad++; $display("FAIL b2b_idle%0d got=%b want=10", k, {mem_stall, dmem_req}); end
         @(posedge clk); #1;
         total++; if ({mem_stall, dmem_req, dmem_addr} !== {2'b11, 64'h200 + 64'(8 * k)}) begin bad++; $display("FAIL b2b_access%0d got=%h want=%h", k, {mem_stall, dmem_req, dmem_addr}, {2'b11, 64'h200 + 64'(8 * k)}); end
         @(posedge clk); #1;
         total++; if ({mem_stall, dmem_req} !== 2'b00) begin bad++; $display("FAIL b2b_done%0d got=%b want=00", k, {mem_stall, dmem_req}); end
         @(posedge clk); #1;
         total++; if ({MEM_WB_rd, MEM_WB_readData} !== {5'(10 + k), 64'hA0 + 64'(k)}) begin bad++; $display("FAIL b2b_wb%0d got=%h want=%h", k, {MEM_WB_rd, MEM_WB_readData}, {5'(10 + k), 64'hA0 + 64'(k)}); end
      end
      clear_ex();
   endtask

   task automatic test_timeout();
      @(negedge clk);
      clear_ex();
      EX_MEM_rd = 5'd4; EX_MEM_ALU_result = 64'h400; EX_MEM_MemRead = 1'b1;
      EX_MEM_regWrite = 1'b1; EX_MEM_MemtoReg = 1'b1; dmem_rdata = 64'hFFFF;
`ifdef MEM_TIMEOUT_EN
      for (int i = 0; i < TO_CYC; i++) begin
         @(posedge clk); #1;
         total++; if ({dmem_req, mem_err} !== 2'b10) begin bad++; $display("FAIL to_access%0d got=%b want=10", i, {dmem_req, mem_err}); end
      end
      @(posedge clk); #1;
      total++; if ({dmem_req, mem_stall, mem_err} !== 3'b001) begin bad++; $display("FAIL to_done got=%b want=001", {dmem_req, mem_stall, mem_err}); end
      @(posedge clk); #1;
      total++; if ({MEM_WB_regWrite, MEM_WB_rd, MEM_WB_readData} !== {1'b1, 5'd4, 64'h0}) begin bad++; $display("FAIL to_wb got=%h want=%h", {MEM_WB_regWrite, MEM_WB_rd, MEM_WB_readData}, {1'b1, 5'd4, 64'h0}); end
      clear_ex();
      repeat (3) @(posedge clk);
      #1;
      total++; if (mem_err !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b want=1", mem_err); end
      @(negedge clk); reset_n = 1'b0; #1;
      total++; if (mem_err !== 1'b0) begin bad++; $display("FAIL to_reset_clear got=%b want=0", mem_err); end
      @(negedge clk); reset_n = 1'b1;
`else
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         total++; if ({dmem_req, mem_stall, mem_err} !== 3'b110) begin bad++; $display("FAIL wait_access%0d got=%b want=110", i, {dmem_req, mem_stall, mem_err}); end
      end
      dmem_ready = 1'b1;
      @(posedge clk); #1;
      dmem_ready = 1'b0;
      total++; if ({dmem_req, mem_stall} !== 2'b00) begin bad++; $display("FAIL wait_done got=%b want=00", {dmem_req, mem_stall}); end
      @(posedge clk); #1;
      total++; if ({MEM_WB_rd, MEM_WB_readData} !== {5'd4, 64'hFFFF}) begin bad++; $display("FAIL wait_wb got=%h want=%h", {MEM_WB_rd, MEM_WB_readData}, {5'd4, 64'hFFFF}); end
      clear_ex();
`endif
   endtask

   task automatic test_reset_mid_access();
      @(negedge clk);
      clear_ex();
      EX_MEM_rd = 5'd9; EX_MEM_ALU_result = 64'h300; EX_MEM_MemRead = 1'b1;
      EX_MEM_regWrite = 1'b1; EX_MEM_MemtoReg = 1'b1;
      @(posedge clk); #1;
      total++; if (dmem_req !== 1'b1) begin bad++; $display("FAIL rst_pre_req got=%b want=1", dmem_req); end
      #2 reset_n = 1'b0;
      #1;
      total++; if (dmem_req !== 1'b0) begin bad++; $display("FAIL rst_req_drop got=%b want=0", dmem_req); end
      total++; if ({MEM_WB_regWrite, MEM_WB_MemtoReg, MEM_WB_rd, MEM_WB_ALU_result, MEM_WB_readData} !== 135'd0) begin bad++; $display("FAIL rst_wb_zero got=%h want=0", {MEM_WB_regWrite, MEM_WB_MemtoReg, MEM_WB_rd, MEM_WB_ALU_result, MEM_WB_readData}); end
      clear_ex();
      @(negedge clk); reset_n = 1'b1;
      @(posedge clk); #1;
      dmem_ready = 1'b1; dmem_rdata = 64'hBAD;
      #1;
      total++; if ({dmem_req, mem_stall} !== 2'b00) begin bad++; $display("FAIL rst_late_ready got=%b want=00", {dmem_req, mem_stall}); end
      @(posedge clk); #1;
      dmem_ready = 1'b0;
      total++; if ({dmem_req, mem_stall, MEM_WB_regWrite, MEM_WB_rd, MEM_WB_readData} !== 72'd0) begin bad++; $display("FAIL rst_after got=%h want=0", {dmem_req, mem_stall, MEM_WB_regWrite, MEM_WB_rd, MEM_WB_readData}); end
   endtask

   initial begin
      test_reset();
      test_alu_op();
      test_load();
      test_branch();
      test_store();
      test_back_to_back();
      test_timeout();
      test_reset_mid_access();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Consumer end of the EX/MEM pipeline register: takes the EX/MEM fields and performs the data-memory access over a req/ready handshake.
- Resolves the branch decision (PCSrc) and drives the MEM/WB pipeline register.
- Holds the upstream pipeline with a stall while a multi-cycle memory access is outstanding.
- Sits between the EX/MEM register and the writeback mux in the 5-stage 64-bit RISC-V core.

Parameters:
- DATA_W, 64, data/address width of ALU result, store data, memory data
- TIMEOUT_CYC, 16, max ACCESS cycles before abort (used only with MEM_TIMEOUT_EN)

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  reset, asynchronous, active-low
- EX_MEM_rd  in  5  destination register
- EX_MEM_readData2  in  DATA_W  store data
- EX_MEM_ALU_result  in  DATA_W  memory address / ALU value
- EX_MEM_zero  in  1  ALU zero flag
- EX_MEM_pcOut  in  DATA_W  branch target
- EX_MEM_Branch, EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_regWrite, EX_MEM_MemtoReg  in  1 each  control
- dmem_req  out  1  memory request valid
- dmem_we  out  1  1 = write
- dmem_addr  out  DATA_W  address
- dmem_wdata  out  DATA_W  write data
- dmem_rdata  in  DATA_W  read data, valid with dmem_ready
- dmem_ready  in  1  memory completion
- mem_stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM
- pc_src  out  1  take branch
- branch_target  out  DATA_W  equals EX_MEM_pcOut
- MEM_WB_rd  out  5
- MEM_WB_ALU_result  out  DATA_W
- MEM_WB_readData  out  DATA_W
- MEM_WB_regWrite  out  1
- MEM_WB_MemtoReg  out  1
- mem_err  out  1  sticky timeout flag (MEM_TIMEOUT_EN only)

Behaviour:
- Reset (reset_n=0, async):
  - state=IDLE.
  - All MEM_WB_* outputs, the read-data capture register and the timeout counter go to 0; mem_err=0.
  - dmem_req drops immediately.
  - A reset mid-access abandons the access; a late dmem_ready is ignored.
- mem_op = EX_MEM_MemRead | EX_MEM_MemWrite.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE, mem_op=0:
    - mem_stall=0.
    - At the next edge MEM_WB loads rd, ALU_result, regWrite, MemtoReg from EX_MEM, with readData=0.
    - Latency 1 cycle.
  - IDLE, mem_op=1: mem_stall=1; MEM_WB loads a bubble; next state ACCESS.
  - ACCESS:
    - Drives dmem_req=1, dmem_addr=EX_MEM_ALU_result, dmem_wdata=EX_MEM_readData2, dmem_we=EX_MEM_MemWrite; mem_stall=1.
    - EX_MEM inputs are stable because upstream is stalled.
    - While dmem_ready=0: stay in ACCESS and keep MEM_WB as a bubble.
    - On dmem_ready=1: capture dmem_rdata (a write captures 0) and go to DONE.
  - DONE:
    - dmem_req=0, mem_stall=0.
    - At the edge MEM_WB loads the EX_MEM fields plus the captured read data; next state IDLE.
    - Upstream advances on the same edge.
  - Minimum memory-op latency is 3 cycles (ready in the first ACCESS cycle).
- Bubble means MEM_WB_regWrite=0, MEM_WB_MemtoReg=0, MEM_WB_rd=0; the other MEM_WB fields are held.
- dmem_req is a registered-state decode; it is only high in ACCESS.
- dmem_ready outside ACCESS is ignored.
- MemRead and MemWrite both 1: treated as a write (dmem_we=1, captured data 0).
- pc_src = EX_MEM_Branch & EX_MEM_zero & ~mem_stall (combinational). branch_target = EX_MEM_pcOut.
- Back-to-back memory ops re-enter ACCESS via IDLE; there is no pipelining of requests.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - An ACCESS-cycle counter resets on entry to ACCESS.
  - If dmem_ready is still 0 in the TIMEOUT_CYC-th ACCESS cycle, go to DONE with captured data 0 and set mem_err=1.
  - mem_err stays 1 until reset; MEM_WB completes normally.
- Undefined:
  - No counter; ACCESS waits indefinitely.
  - mem_err is tied to 0 (port still present).

Test Plan:
- ALU op, regWrite=1, rd=5, ALU_result=0x2A, no mem → next edge MEM_WB_rd=5, ALU_result=0x2A, regWrite=1; mem_stall never high.
- Load, addr=0x100, dmem_ready held 1, rdata=0xDEADBEEF → mem_stall high 2 cycles, dmem_req high 1 cycle with addr 0x100, we=0; MEM_WB_readData=0xDEADBEEF and MemtoReg=1 on the third edge; bubbles before.
- Store, addr=0x80, data=0x55, dmem_ready delayed 4 cycles → dmem_req/we held 4 cycles with stable addr/wdata; MEM_WB_regWrite=0 throughout and readData=0.
- Branch=1, zero=1, pcOut=0x40 → pc_src=1, branch_target=0x40. With zero=0 → pc_src=0.
- reset_n low during ACCESS, then ready pulsed after release → dmem_req drops immediately; state IDLE; pulse ignored; all MEM_WB_* = 0.
- MEM_TIMEOUT_EN, TIMEOUT_CYC=4, ready never asserted → after 4 ACCESS cycles DONE, MEM_WB_readData=0, mem_err=1 sticky until reset.
